// File: rtl/pwm_pkg.sv
// Shared constants and width helpers for the multichannel PWM block.
package pwm_pkg;

    localparam int PWM_WIDTH    = 8;
    localparam int PWM_CHANNELS = 4;

    // Duty needs one extra bit so that "always high" (period+1) fits.
    function automatic int duty_w(input int width);
        return width + 1;
    endfunction

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: compare shared counter with active duty,
// apply polarity and register the result.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic [WIDTH-1:0]         counter_i,
    input  logic [duty_w(WIDTH)-1:0] duty_i,
    input  logic                     pol_i,
    output logic                     pwm_o
);

    logic raw;
    logic out_d;
    logic out_q;

    assign raw = ({1'b0, counter_i} < duty_i);

    always_comb begin
        out_d = pol_i;
        if (en_i) begin
            out_d = raw ^ pol_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

    assign pwm_o = out_q;

endmodule

// File: rtl/pwm_multichannel.sv
// Multichannel PWM: shared counter, shadowed period/duty registers
// that load into the active set only at wrap or while idle.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int WIDTH    = PWM_WIDTH,
    parameter int CHANNELS = PWM_CHANNELS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      period_wr,
    input  logic [WIDTH-1:0]          period_in,
    input  logic                      duty_wr,
    input  logic [ch_w(CHANNELS)-1:0] duty_ch,
    input  logic [duty_w(WIDTH)-1:0]  duty_in,
    input  logic [CHANNELS-1:0]       polarity,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_done,
    output logic [WIDTH-1:0]          counter
);

    localparam int DW = duty_w(WIDTH);
    localparam int CW = ch_w(CHANNELS);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] per_sh_q, per_sh_d;
    logic [WIDTH-1:0] per_act_q, per_act_d;
    logic [DW-1:0]    duty_sh_q  [CHANNELS];
    logic [DW-1:0]    duty_sh_d  [CHANNELS];
    logic [DW-1:0]    duty_act_q [CHANNELS];
    logic [DW-1:0]    duty_act_d [CHANNELS];
    logic             done_q, done_d;
    logic             wrap;
    logic             load;

    assign wrap = en && (cnt_q == per_act_q);
    // Actives take the pre-write shadow, so a write in this cycle waits.
    assign load = wrap || !en;

    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        per_sh_d  = per_sh_q;
        per_act_d = per_act_q;
        done_d    = wrap;
        if (load) begin
            cnt_d     = '0;
            per_act_d = per_sh_q;
        end
        if (period_wr) begin
            per_sh_d = period_in;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            duty_sh_d[i]  = duty_sh_q[i];
            duty_act_d[i] = duty_act_q[i];
            if (load) begin
                duty_act_d[i] = duty_sh_q[i];
            end
            if (duty_wr && (int'(duty_ch) < CHANNELS)
                && (duty_ch == CW'(i))) begin
                duty_sh_d[i] = duty_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            per_sh_q  <= '0;
            per_act_q <= '0;
            done_q    <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            per_sh_q   <= per_sh_d;
            per_act_q  <= per_act_d;
            done_q     <= done_d;
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en_i     (en),
            .counter_i(cnt_q),
            .duty_i   (duty_act_q[g]),
            .pol_i    (polarity[g]),
            .pwm_o    (pwm_out[g])
        );
    end

    assign period_done = done_q;
    assign counter     = cnt_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel (4-channel main build
// plus a 6-channel build for out-of-range channel writes).
module tb_pwm_multichannel;

    logic       clk;
    logic       rst;
    logic       en;
    logic       period_wr;
    logic [7:0] period_in;
    logic       duty_wr;
    logic [1:0] duty_ch;
    logic [8:0] duty_in;
    logic [3:0] polarity;
    logic [3:0] pwm_out;
    logic       period_done;
    logic [7:0] counter;

    logic       duty_wr6;
    logic [2:0] duty_ch6;
    logic [5:0] polarity6;
    logic [5:0] pwm6;
    logic       done6;
    logic [7:0] cnt6;

    int vecs = 0;
    int errs = 0;

    pwm_multichannel #(
        .WIDTH   (8),
        .CHANNELS(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .period_wr  (period_wr),
        .period_in  (period_in),
        .duty_wr    (duty_wr),
        .duty_ch    (duty_ch),
        .duty_in    (duty_in),
        .polarity   (polarity),
        .pwm_out    (pwm_out),
        .period_done(period_done),
        .counter    (counter)
    );

    pwm_multichannel #(
        .WIDTH   (8),
        .CHANNELS(6)
    ) dut6 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .period_wr  (period_wr),
        .period_in  (period_in),
        .duty_wr    (duty_wr6),
        .duty_ch    (duty_ch6),
        .duty_in    (duty_in),
        .polarity   (polarity6),
        .pwm_out    (pwm6),
        .period_done(done6),
        .counter    (cnt6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr_period(input logic [7:0] v);
        period_in = v;
        period_wr = 1'b1;
        cyc();
        period_wr = 1'b0;
    endtask

    task automatic wr_duty(input logic [1:0] ch, input logic [8:0] v);
        duty_ch = ch;
        duty_in = v;
        duty_wr = 1'b1;
        cyc();
        duty_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b0;
        polarity = 4'b1111;
        repeat (2) cyc();
        vecs++;
        if (counter !== 8'd0) begin
            errs++;
            $display("FAIL rst_cnt: got %0d want 0", counter);
        end
        vecs++;
        if (pwm_out !== 4'b0000) begin
            errs++;
            $display("FAIL rst_pwm: got %b want 0000", pwm_out);
        end
        vecs++;
        if (period_done !== 1'b0) begin
            errs++;
            $display("FAIL rst_done: got %b want 0", period_done);
        end
        vecs++;
        if (pwm6 !== 6'b0) begin
            errs++;
            $display("FAIL rst_pwm6: got %b want 000000", pwm6);
        end
        rst = 1'b0;
        cyc();
        vecs++;
        if (pwm_out !== 4'b1111) begin
            errs++;
            $display("FAIL idle_pol: got %b want 1111", pwm_out);
        end
        polarity = 4'b0000;
    endtask

    task automatic test_basic();
        int highs;
        int dones;
        int p;
        highs = 0;
        dones = 0;
        en = 1'b0;
        wr_period(8'd9);
        wr_duty(2'd0, 9'd3);
        wr_duty(2'd1, 9'd3);
        cyc();
        en = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            p = k - 1;
            vecs++;
            if (counter !== 8'(k % 10)) begin
                errs++;
                $display("FAIL basic_cnt k=%0d: got %0d want %0d",
                         k, counter, k % 10);
            end
            vecs++;
            if (pwm_out[0] !== (p % 10 < 3)) begin
                errs++;
                $display("FAIL basic_pwm k=%0d: got %b want %b",
                         k, pwm_out[0], (p % 10 < 3));
            end
            vecs++;
            if (period_done !== (p % 10 == 9)) begin
                errs++;
                $display("FAIL basic_done k=%0d: got %b want %b",
                         k, period_done, (p % 10 == 9));
            end
            highs += int'(pwm_out[0]);
            dones += int'(period_done);
        end
        vecs++;
        if (highs != 9) begin
            errs++;
            $display("FAIL basic_highs: got %0d want 9", highs);
        end
        vecs++;
        if (dones != 3) begin
            errs++;
            $display("FAIL basic_dones: got %0d want 3", dones);
        end
    endtask

    task automatic test_mid_update();
        int p;
        int d;
        repeat (4) cyc();
        vecs++;
        if (counter !== 8'd4) begin
            errs++;
            $display("FAIL upd_start: got %0d want 4", counter);
        end
        duty_ch = 2'd1;
        duty_in = 9'd7;
        duty_wr = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            duty_wr = 1'b0;
            p = 3 + k;
            d = (p < 10) ? 3 : 7;
            vecs++;
            if (counter !== 8'((4 + k) % 10)) begin
                errs++;
                $display("FAIL upd_cnt k=%0d: got %0d want %0d",
                         k, counter, (4 + k) % 10);
            end
            vecs++;
            if (pwm_out[1:0] !== {(p % 10 < d), (p % 10 < 3)}) begin
                errs++;
                $display("FAIL upd_pwm k=%0d: got %b want %b%b",
                         k, pwm_out[1:0], (p % 10 < d), (p % 10 < 3));
            end
        end
    endtask

    task automatic test_wrap_write();
        int p;
        int d;
        repeat (5) cyc();
        vecs++;
        if (counter !== 8'd9) begin
            errs++;
            $display("FAIL wrw_start: got %0d want 9", counter);
        end
        duty_ch = 2'd0;
        duty_in = 9'd5;
        duty_wr = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            duty_wr = 1'b0;
            p = 8 + k;
            d = (p < 20) ? 3 : 5;
            vecs++;
            if (pwm_out[0] !== (p % 10 < d)) begin
                errs++;
                $display("FAIL wrw_pwm k=%0d: got %b want %b",
                         k, pwm_out[0], (p % 10 < d));
            end
            vecs++;
            if (period_done !== (p % 10 == 9)) begin
                errs++;
                $display("FAIL wrw_done k=%0d: got %b want %b",
                         k, period_done, (p % 10 == 9));
            end
        end
    endtask

    task automatic test_extremes();
        int p;
        logic [3:0] exp;
        en = 1'b0;
        period_in = 8'd255;
        period_wr = 1'b1;
        duty_ch = 2'd3;
        duty_in = 9'd256;
        duty_wr = 1'b1;
        cyc();
        period_wr = 1'b0;
        duty_wr = 1'b0;
        wr_duty(2'd2, 9'd0);
        cyc();
        en = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            cyc();
            p = (k - 1) % 256;
            exp = {1'b1, 1'b0, (p < 7), (p < 5)};
            vecs++;
            if (counter !== 8'(k % 256)) begin
                errs++;
                $display("FAIL ext_cnt k=%0d: got %0d want %0d",
                         k, counter, k % 256);
            end
            vecs++;
            if (pwm_out !== exp) begin
                errs++;
                $display("FAIL ext_pwm k=%0d: got %b want %b",
                         k, pwm_out, exp);
            end
            vecs++;
            if (period_done !== (p == 255)) begin
                errs++;
                $display("FAIL ext_done k=%0d: got %b want %b",
                         k, period_done, (p == 255));
            end
        end
    endtask

    task automatic test_period_zero();
        en = 1'b0;
        wr_period(8'd0);
        wr_duty(2'd0, 9'd1);
        wr_duty(2'd1, 9'd0);
        cyc();
        en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            vecs++;
            if (counter !== 8'd0) begin
                errs++;
                $display("FAIL p0_cnt k=%0d: got %0d want 0", k, counter);
            end
            vecs++;
            if (period_done !== 1'b1) begin
                errs++;
                $display("FAIL p0_done k=%0d: got %b want 1",
                         k, period_done);
            end
            vecs++;
            if (pwm_out !== 4'b1001) begin
                errs++;
                $display("FAIL p0_pwm k=%0d: got %b want 1001",
                         k, pwm_out);
            end
        end
    endtask

    task automatic test_idle_polarity();
        polarity = 4'b0101;
        en = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            vecs++;
            if (pwm_out !== 4'b0101) begin
                errs++;
                $display("FAIL idle_pwm k=%0d: got %b want 0101",
                         k, pwm_out);
            end
            vecs++;
            if (counter !== 8'd0) begin
                errs++;
                $display("FAIL idle_cnt k=%0d: got %0d want 0", k, counter);
            end
            vecs++;
            if (period_done !== 1'b0) begin
                errs++;
                $display("FAIL idle_done k=%0d: got %b want 0",
                         k, period_done);
            end
        end
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            vecs++;
            if (pwm_out !== 4'b1100) begin
                errs++;
                $display("FAIL pol_run k=%0d: got %b want 1100",
                         k, pwm_out);
            end
        end
        polarity = 4'b0000;
    endtask

    task automatic test_invalid_ch();
        logic [5:0] exp;
        en = 1'b0;
        wr_period(8'd9);
        duty_in = 9'd2;
        duty_ch6 = 3'd5;
        duty_wr6 = 1'b1;
        cyc();
        duty_in = 9'd5;
        duty_ch6 = 3'd6;
        cyc();
        duty_in = 9'd9;
        duty_ch6 = 3'd7;
        cyc();
        duty_wr6 = 1'b0;
        cyc();
        en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            exp = ((k - 1) % 10 < 2) ? 6'b100000 : 6'b000000;
            vecs++;
            if (cnt6 !== 8'(k % 10)) begin
                errs++;
                $display("FAIL inv_cnt k=%0d: got %0d want %0d",
                         k, cnt6, k % 10);
            end
            vecs++;
            if (pwm6 !== exp) begin
                errs++;
                $display("FAIL inv_pwm k=%0d: got %b want %b",
                         k, pwm6, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat (3) cyc();
        wr_period(8'd20);
        cyc();
        vecs++;
        if (counter !== 8'd5) begin
            errs++;
            $display("FAIL rmid_start: got %0d want 5", counter);
        end
        rst = 1'b1;
        cyc();
        vecs++;
        if ({counter, pwm_out, period_done} !== 13'd0) begin
            errs++;
            $display("FAIL rmid_clr: got cnt=%0d pwm=%b done=%b want 0",
                     counter, pwm_out, period_done);
        end
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            vecs++;
            if (counter !== 8'd0) begin
                errs++;
                $display("FAIL rmid_cnt k=%0d: got %0d want 0", k, counter);
            end
            vecs++;
            if (period_done !== 1'b1) begin
                errs++;
                $display("FAIL rmid_done k=%0d: got %b want 1",
                         k, period_done);
            end
            vecs++;
            if (pwm_out !== 4'b0000) begin
                errs++;
                $display("FAIL rmid_pwm k=%0d: got %b want 0000",
                         k, pwm_out);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        period_wr = 1'b0;
        period_in = 8'd0;
        duty_wr = 1'b0;
        duty_ch = 2'd0;
        duty_in = 9'd0;
        polarity = 4'b0000;
        duty_wr6 = 1'b0;
        duty_ch6 = 3'd0;
        polarity6 = 6'b0;
        test_reset();
        test_basic();
        test_mid_update();
        test_wrap_write();
        test_extremes();
        test_period_zero();
        test_idle_polarity();
        test_invalid_ch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
